fp_adder_arbiter: RTL and testbench

Shares a pool of two floating-point adder lanes among `NUM_REQ` sequencing blocks (angle combination, state update, etc.), each of which drives the same two-lane start/ready adder interface it would use with dedicated adders. Ownership is granted round-robin and held until the owner releases it. Start and operands are forwarded through one register stage. Ready is masked so the owner never sees a stale result from an earlier operation.

---
 rtl/fp_pkg.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/fp_adder_arbiter.sv | 138 +++++++++++++
 tb/tb_fp_adder_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point word type and adder-arbiter state encoding
package fp_pkg;

    localparam int EXP_LEN      = 8;
    localparam int MANTISSA_LEN = 23;
    localparam int FP_W         = EXP_LEN + MANTISSA_LEN + 1;

    typedef logic [FP_W-1:0] fp_word_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr, cyclically
module rr_pick #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest set request wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr, k)]) idx = wrap_idx(ptr, k);
        end
    end

endmodule

// File: rtl/fp_adder_arbiter.sv
// rtl/fp_adder_arbiter.sv - round-robin sharing of two fp adder lanes among NUM_REQ sequencers
module fp_adder_arbiter #(
    parameter  int EXP_LEN      = fp_pkg::EXP_LEN,
    parameter  int MANTISSA_LEN = fp_pkg::MANTISSA_LEN,
    parameter  int NUM_REQ      = 3,
    localparam int W            = EXP_LEN + MANTISSA_LEN + 1,
    localparam int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    output logic [NUM_REQ-1:0]               gnt,
    input  logic [NUM_REQ-1:0][1:0]          req_add_start,
    input  logic [NUM_REQ-1:0][1:0][W-1:0]   req_add_a,
    input  logic [NUM_REQ-1:0][1:0][W-1:0]   req_add_b,
    output logic [NUM_REQ-1:0][1:0][W-1:0]   req_add_sum,
    output logic [NUM_REQ-1:0][1:0]          req_add_ready,
    output logic [1:0]                       adder_start,
    output logic [1:0][W-1:0]                adder_a,
    output logic [1:0][W-1:0]                adder_b,
    input  logic [1:0][W-1:0]                adder_sum,
    input  logic [1:0]                       adder_ready,
    output logic                             busy,
    output logic [IW-1:0]                    owner
);

    import fp_pkg::*;

    arb_state_t    state;
    logic [IW-1:0] rr_ptr;
    logic [1:0]    pending;
    logic [1:0]    start_nxt;
    logic          owner_req;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_req = req[owner];

    // Starts are forwarded only from a live owner; the release cycle and DRAIN send none.
    always_comb begin
        start_nxt = 2'b00;
        if (state == ARB_OWN && owner_req) start_nxt = req_add_start[owner];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            gnt         <= '0;
            busy        <= 1'b0;
            owner       <= '0;
            rr_ptr      <= '0;
            adder_start <= '0;
            adder_a     <= '0;
            adder_b     <= '0;
        end else begin
            adder_start <= start_nxt;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state  <= ARB_OWN;
                        gnt    <= NUM_REQ'(1) << pick_idx;
                        busy   <= 1'b1;
                        owner  <= pick_idx;
                        rr_ptr <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end
                ARB_OWN: begin
                    adder_a <= req_add_a[owner];
                    adder_b <= req_add_b[owner];
                    if (!owner_req) begin
                        if (pending == 2'b00) begin
                            state <= ARB_IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            state <= ARB_DRAIN;
                        end
                    end
                end
                ARB_DRAIN: begin
                    if (pending == 2'b00) begin
                        state <= ARB_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A lane completes only after ready has been seen low, so a ready left high
    // from an earlier operation never reaches the owner.
    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic pend_q;
        logic seen_low;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pend_q   <= 1'b0;
                seen_low <= 1'b0;
            end else if (start_nxt[l]) begin
                pend_q   <= 1'b1;
                seen_low <= 1'b0;
            end else if (pend_q && seen_low && adder_ready[l]) begin
                pend_q   <= 1'b0;
                seen_low <= 1'b0;
            end else if (pend_q && !adder_ready[l]) begin
                seen_low <= 1'b1;
            end
        end

        assign pending[l] = pend_q;
    end

    always_comb begin
        req_add_ready = '0;
        req_add_sum   = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r] && owner == IW'(r)) begin
                req_add_ready[r] = adder_ready & ~pending;
                req_add_sum[r]   = adder_sum;
            end
        end
    end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// tb/tb_fp_adder_arbiter.sv - directed self-checking bench for fp_adder_arbiter
module tb_fp_adder_arbiter;
    import fp_pkg::*;

    localparam int N = 3;
    localparam int W = FP_W;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N-1:0]             req;
    logic [N-1:0]             gnt;
    logic [N-1:0][1:0]        req_add_start;
    logic [N-1:0][1:0][W-1:0] req_add_a;
    logic [N-1:0][1:0][W-1:0] req_add_b;
    logic [N-1:0][1:0][W-1:0] req_add_sum;
    logic [N-1:0][1:0]        req_add_ready;
    logic [1:0]               adder_start;
    logic [1:0][W-1:0]        adder_a;
    logic [1:0][W-1:0]        adder_b;
    logic [1:0][W-1:0]        adder_sum;
    logic [1:0]               adder_ready;
    logic                     busy;
    logic [1:0]               owner;

    fp_adder_arbiter #(.EXP_LEN(8), .MANTISSA_LEN(23), .NUM_REQ(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .gnt           (gnt),
        .req_add_start (req_add_start),
        .req_add_a     (req_add_a),
        .req_add_b     (req_add_b),
        .req_add_sum   (req_add_sum),
        .req_add_ready (req_add_ready),
        .adder_start   (adder_start),
        .adder_a       (adder_a),
        .adder_b       (adder_b),
        .adder_sum     (adder_sum),
        .adder_ready   (adder_ready),
        .busy          (busy),
        .owner         (owner)
    );

    always #5 clk = ~clk;

    // Physical adder model: ready drops the cycle after start, returns lat cycles after start.
    int       lat [2];
    int       cnt [2];
    fp_word_t op_a [2];
    fp_word_t op_b [2];

    function automatic fp_word_t fadd(input fp_word_t a, input fp_word_t b);
        case ({a, b})
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h40000000, 32'h3F800000}: return 32'h40400000;
            {32'h3FC00000, 32'h3FC00000}: return 32'h40400000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h00000000, 32'h3F800000}: return 32'h3F800000;
            {32'h3F800000, 32'hBF800000}: return 32'h00000000;
            {32'h40400000, 32'h3F800000}: return 32'h40800000;
            {32'h40800000, 32'h40800000}: return 32'h41000000;
            default:                      return 32'hFFFFFFFF;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            adder_ready <= 2'b11;
            adder_sum   <= '0;
            for (int l = 0; l < 2; l++) cnt[l] <= 0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (adder_start[l]) begin
                    adder_ready[l] <= 1'b0;
                    cnt[l]         <= lat[l] - 1;
                    op_a[l]        <= adder_a[l];
                    op_b[l]        <= adder_b[l];
                end else if (cnt[l] == 1) begin
                    adder_ready[l] <= 1'b1;
                    adder_sum[l]   <= fadd(op_a[l], op_b[l]);
                    cnt[l]         <= 0;
                end else if (cnt[l] > 1) begin
                    cnt[l] <= cnt[l] - 1;
                end
            end
        end
    end

    typedef struct {
        fp_word_t a0, b0, a1, b1;
        fp_word_t s0, s1;
        int       lat;
    } vec_t;

    vec_t vec [4];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int ar_rise;
        int mr_rise;
        bit seen_drop;
        bit bad_start;

        vec[0] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h40400000, 4};
        vec[1] = '{32'h3FC00000, 32'h3FC00000, 32'h40000000, 32'h40000000, 32'h40400000, 32'h40800000, 3};
        vec[2] = '{32'h00000000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h00000000, 2};
        vec[3] = '{32'h40400000, 32'h3F800000, 32'h40800000, 32'h40800000, 32'h40800000, 32'h41000000, 5};

        reset = 1'b1;
        req = '0;
        req_add_start = '0;
        req_add_a = '0;
        req_add_b = '0;
        lat[0] = 4;
        lat[1] = 4;
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", adder_start, 0);
        chk("rst_owner", owner, 0);
        chk("rst_adder_a", adder_a, 0);
        reset = 1'b0;

        // Single requester, table of two-lane adds
        req = 3'b001;
        tick();
        chk("grant_gnt", gnt, 3'b001);
        chk("grant_busy", busy, 1);
        chk("grant_owner", owner, 0);
        for (int i = 0; i < 4; i++) begin
            lat[0] = vec[i].lat;
            lat[1] = vec[i].lat;
            req_add_a[0][0] = vec[i].a0;
            req_add_b[0][0] = vec[i].b0;
            req_add_a[0][1] = vec[i].a1;
            req_add_b[0][1] = vec[i].b1;
            req_add_start[0] = 2'b11;
            tick();
            req_add_start[0] = 2'b00;
            chk("vec_adder_start", adder_start, 2'b11);
            chk("vec_adder_a0", adder_a[0], vec[i].a0);
            chk("vec_adder_b1", adder_b[1], vec[i].b1);
            chk("vec_ready_masked", req_add_ready[0], 2'b00);
            cyc = 1;
            while (req_add_ready[0] != 2'b11 && cyc < 40) begin
                tick();
                cyc++;
            end
            chk("vec_latency", cyc, vec[i].lat + 2);
            chk("vec_sum0", req_add_sum[0][0], vec[i].s0);
            chk("vec_sum1", req_add_sum[0][1], vec[i].s1);
            tick();
        end

        // Stale-ready mask with a 3-cycle adder on lane 0
        lat[0] = 3;
        req_add_a[0][0] = 32'h3F800000;
        req_add_b[0][0] = 32'h3F800000;
        req_add_start[0] = 2'b01;
        tick();
        req_add_start[0] = 2'b00;
        chk("stale_first_cycle", req_add_ready[0][0], 0);
        ar_rise = -1;
        mr_rise = -1;
        seen_drop = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (!adder_ready[0]) seen_drop = 1'b1;
            if (seen_drop && adder_ready[0] && ar_rise < 0) ar_rise = c;
            if (req_add_ready[0][0] && mr_rise < 0) mr_rise = c;
            tick();
        end
        chk("stale_adder_rise", ar_rise, 4);
        chk("stale_masked_rise", mr_rise, 5);

        // Release with nothing pending
        req = 3'b000;
        tick();
        chk("release_gnt", gnt, 0);
        chk("release_busy", busy, 0);

        // Contention from reset
        reset = 1'b1;
        req = 3'b111;
        tick();
        reset = 1'b0;
        tick();
        chk("cont_gnt0", gnt, 3'b001);
        req[0] = 1'b0;
        tick();
        chk("cont_gap0", gnt, 3'b000);
        tick();
        chk("cont_gnt1", gnt, 3'b010);
        chk("cont_owner1", owner, 1);
        req[0] = 1'b1;
        req[1] = 1'b0;
        tick();
        chk("cont_gap1", gnt, 3'b000);
        tick();
        chk("cont_gnt2", gnt, 3'b100);
        chk("cont_owner2", owner, 2);
        req[2] = 1'b0;
        tick();
        chk("cont_gap2", gnt, 3'b000);
        tick();
        chk("cont_gnt_wrap", gnt, 3'b001);
        req[0] = 1'b0;
        tick();

        // Drain: owner drops req one cycle after its start
        req = 3'b001;
        tick();
        chk("drain_grant", gnt, 3'b001);
        lat[0] = 3;
        req_add_a[0][0] = 32'h3F800000;
        req_add_b[0][0] = 32'h3F800000;
        req_add_start[0] = 2'b01;
        tick();
        req = 3'b000;
        req_add_start[0] = 2'b11;
        tick();
        chk("drain_gnt_held", gnt, 3'b001);
        chk("drain_busy", busy, 1);
        chk("drain_no_start", adder_start, 2'b00);
        tick();
        req_add_start[0] = 2'b00;
        bad_start = 1'b0;
        cyc = 3;
        while (!req_add_ready[0][0] && cyc < 40) begin
            if (adder_start != 2'b00) bad_start = 1'b1;
            tick();
            cyc++;
        end
        chk("drain_start_quiet", bad_start, 0);
        chk("drain_result_cycle", cyc, 5);
        chk("drain_sum", req_add_sum[0][0], 32'h40000000);
        chk("drain_gnt_at_result", gnt, 3'b001);
        tick();
        chk("drain_release", gnt, 3'b000);
        chk("drain_busy_low", busy, 0);

        // Isolation of a non-owner
        req = 3'b001;
        req_add_a[0][0] = 32'h3F800000;
        req_add_a[0][1] = 32'h40000000;
        tick();
        tick();
        req_add_start[2] = 2'b11;
        req_add_a[2][0] = 32'h40400000;
        req_add_a[2][1] = 32'h40400000;
        req_add_b[2][0] = 32'h40400000;
        req_add_b[2][1] = 32'h40400000;
        #1;
        chk("iso_ready2_comb", req_add_ready[2], 0);
        tick();
        req_add_start[2] = 2'b00;
        chk("iso_adder_start", adder_start, 2'b00);
        chk("iso_adder_a0", adder_a[0], 32'h3F800000);
        chk("iso_adder_a1", adder_a[1], 32'h40000000);
        chk("iso_ready2", req_add_ready[2], 0);
        chk("iso_sum2", req_add_sum[2], 0);
        chk("iso_owner_ready", req_add_ready[0], 2'b11);

        // Reset while lane 0 is pending
        lat[0] = 4;
        req_add_start[0] = 2'b01;
        tick();
        req_add_start[0] = 2'b00;
        chk("mid_pending_ready", req_add_ready[0][0], 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", adder_start, 0);
        chk("mid_rst_a", adder_a, 0);
        chk("mid_rst_b", adder_b, 0);
        chk("mid_rst_owner", owner, 0);
        chk("mid_rst_ready", req_add_ready, 0);
        chk("mid_rst_sum0", req_add_sum[0], 0);
        req = 3'b010;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_gnt", gnt, 3'b010);
        chk("post_rst_owner", owner, 1);
        chk("post_rst_ready1", req_add_ready[1], 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
